// File: rtl/ppu_reg_pkg.sv
// Shared definitions for the CPU-side PPU register interface.
// Holds register index constants, the access FSM state encoding,
// parameter defaults, PPUCTRL/PPUSTATUS bit positions and the status
// byte packer.
package ppu_reg_pkg;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_MASK    = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_OAMADDR = 3'd3;
  localparam logic [2:0] REG_OAMDATA = 3'd4;
  localparam logic [2:0] REG_SCROLL  = 3'd5;
  localparam logic [2:0] REG_ADDR    = 3'd6;
  localparam logic [2:0] REG_DATA    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_VRAM_RD = 2'd1,
    ST_VRAM_WR = 2'd2,
    ST_DONE    = 2'd3
  } ppu_if_state_e;

  localparam logic [13:0] PAL_BASE_DEF  = 14'h3F00;
  localparam int          INC_LARGE_DEF = 32;

  // PPUCTRL bits
  localparam int CTRL_NMI_EN = 7;
  localparam int CTRL_INC32  = 2;

  // PPUSTATUS bits
  localparam int STAT_VBLANK = 7;
  localparam int STAT_SPR0   = 6;
  localparam int STAT_OVF    = 5;

  function automatic logic [7:0] status_byte(input logic vbl, input logic s0,
                                             input logic ovf, input logic [4:0] low5);
    return {vbl, s0, ovf, low5};
  endfunction

endpackage

// File: rtl/ppu_loopy_regs.sv
// Loopy scroll/address registers: v (current VRAM addr), t (temp addr),
// x (fine X) and w (write toggle).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en, idx, din register write strobe, index and data ($2000/$2005/$2006 used)
//   clr_w           $2002 read, resets the write toggle
//   inc_en          $2007 access completed, advance v
//   inc_large       PPUCTRL bit2: step by INC_LARGE instead of 1
//   v, t, x, w      register contents
module ppu_loopy_regs
  import ppu_reg_pkg::*;
#(
  parameter int INC_LARGE = INC_LARGE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  idx,
  input  logic [7:0]  din,
  input  logic        clr_w,
  input  logic        inc_en,
  input  logic        inc_large,
  output logic [14:0] v,
  output logic [14:0] t,
  output logic [2:0]  x,
  output logic        w
);

  localparam logic [14:0] STEP_L = 15'(INC_LARGE);

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      t <= '0;
      x <= '0;
      w <= 1'b0;
    end else begin
      if (clr_w) w <= 1'b0;
      if (wr_en) begin
        case (idx)
          REG_CTRL: t[11:10] <= din[1:0];
          REG_SCROLL: begin
            if (!w) begin
              t[4:0] <= din[7:3];
              x      <= din[2:0];
            end else begin
              t[14:12] <= din[2:0];
              t[9:5]   <= din[7:3];
            end
            w <= ~w;
          end
          REG_ADDR: begin
            if (!w) begin
              t[13:8] <= din[5:0];
              t[14]   <= 1'b0;
            end else begin
              t[7:0] <= din;
              // v takes the just-written low byte, not the stale t[7:0]
              v      <= {t[14:8], din};
            end
            w <= ~w;
          end
          default: ;
        endcase
      end
      // wraps naturally at 15 bits
      if (inc_en) v <= v + (inc_large ? STEP_L : 15'd1);
    end
  end

endmodule

// File: rtl/cpu_ppu_reg_if.sv
// CPU-side PPU register file ($2000-$2007) and VRAM access port.
// Register accesses complete in one cycle; $2007 goes through a
// req/ack handshake to VRAM while cpu_rdy stays low.
// Optional feature macro: PPU_OPEN_BUS_EN (open-bus data latch returned
// on write-only register reads and in $2002 low bits).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   addr_in, addr_valid      decoded CPU address; addr_valid=1 means memory (ignored)
//   cpu_rd, cpu_wr, cpu_din  access strobes (held until cpu_rdy) and write data
//   cpu_dout, cpu_rdy        read data and one-cycle completion pulse
//   vblank_set, vblank_clr   vblank flag pulses from PPU timing
//   spr0_hit, spr_ovf        sprite status levels
//   ppu_ctrl, ppu_mask       $2000/$2001 contents
//   scroll_t, fine_x         loopy t and fine X
//   oam_*                    OAM address / write port / read data
//   vram_*                   VRAM req/ack port for $2007
//   nmi_out                  ppu_ctrl[7] & vblank flag
module cpu_ppu_reg_if
  import ppu_reg_pkg::*;
#(
  parameter logic [13:0] PAL_BASE  = PAL_BASE_DEF,
  parameter int          INC_LARGE = INC_LARGE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr_in,
  input  logic        addr_valid,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_rdy,
  input  logic        vblank_set,
  input  logic        vblank_clr,
  input  logic        spr0_hit,
  input  logic        spr_ovf,
  output logic [7:0]  ppu_ctrl,
  output logic [7:0]  ppu_mask,
  output logic [14:0] scroll_t,
  output logic [2:0]  fine_x,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  input  logic [7:0]  oam_rdata,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_rd,
  output logic        vram_wr,
  input  logic        vram_ack,
  input  logic [7:0]  vram_rdata,
  output logic        nmi_out
);

  ppu_if_state_e state;
  logic [7:0]    read_buf;
  logic          vblank_flag;
  logic [14:0]   v;
  logic          w_unused;

  logic [2:0] idx;
  logic       sel, accept, reg_acc, rd_status, vram_done;
  logic [7:0] open_val, status_val, rd_mux, vram_rd_val;

  assign idx       = addr_in[2:0];
  assign sel       = (cpu_rd | cpu_wr) & ~addr_valid & (addr_in[15:3] == 13'h0400);
  assign accept    = (state == ST_IDLE) & sel;
  assign reg_acc   = accept & (idx != REG_DATA);
  assign rd_status = reg_acc & ~cpu_wr & (idx == REG_STATUS);
  assign vram_done = ((state == ST_VRAM_RD) | (state == ST_VRAM_WR)) & vram_ack;

  ppu_loopy_regs #(.INC_LARGE(INC_LARGE)) u_loopy (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (reg_acc & cpu_wr),
    .idx       (idx),
    .din       (cpu_din),
    .clr_w     (rd_status),
    .inc_en    (vram_done),
    .inc_large (ppu_ctrl[CTRL_INC32]),
    .v         (v),
    .t         (scroll_t),
    .x         (fine_x),
    .w         (w_unused)
  );

  // A set pulse coinciding with the status read is hidden from the read
  // and then dropped by the flag update below.
  assign status_val  = status_byte(vblank_flag & ~vblank_set, spr0_hit, spr_ovf, open_val[4:0]);
  assign vram_rd_val = (vram_addr >= PAL_BASE) ? vram_rdata : read_buf;

  always_comb begin
    rd_mux = open_val;
    case (idx)
      REG_STATUS:  rd_mux = status_val;
      REG_OAMDATA: rd_mux = oam_rdata;
      default:     rd_mux = open_val;
    endcase
  end

`ifdef PPU_OPEN_BUS_EN
  logic [7:0] bus_latch;
  always_ff @(posedge clk) begin
    if (rst)                                      bus_latch <= '0;
    else if (accept & cpu_wr)                     bus_latch <= cpu_din;
    else if (reg_acc & (idx == REG_STATUS))       bus_latch <= status_val;
    else if (reg_acc & (idx == REG_OAMDATA))      bus_latch <= oam_rdata;
    else if (vram_done & (state == ST_VRAM_RD))   bus_latch <= vram_rd_val;
  end
  assign open_val = bus_latch;
`else
  assign open_val = 8'h00;
`endif

  // Clear has priority over both the read-clear and the set.
  always_ff @(posedge clk) begin
    if (rst)             vblank_flag <= 1'b0;
    else if (vblank_clr) vblank_flag <= 1'b0;
    else if (rd_status)  vblank_flag <= 1'b0;
    else if (vblank_set) vblank_flag <= 1'b1;
  end

  assign nmi_out = ppu_ctrl[CTRL_NMI_EN] & vblank_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cpu_dout   <= '0;
      cpu_rdy    <= 1'b0;
      ppu_ctrl   <= '0;
      ppu_mask   <= '0;
      oam_addr   <= '0;
      oam_wdata  <= '0;
      oam_we     <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= '0;
      vram_rd    <= 1'b0;
      vram_wr    <= 1'b0;
      read_buf   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel) begin
            if (idx == REG_DATA) begin
              vram_addr <= v[13:0];
              if (cpu_wr) begin
                vram_wr    <= 1'b1;
                vram_wdata <= cpu_din;
                state      <= ST_VRAM_WR;
              end else begin
                vram_rd <= 1'b1;
                state   <= ST_VRAM_RD;
              end
            end else begin
              if (cpu_wr) begin
                case (idx)
                  REG_CTRL:    ppu_ctrl <= cpu_din;
                  REG_MASK:    ppu_mask <= cpu_din;
                  REG_OAMADDR: oam_addr <= cpu_din;
                  REG_OAMDATA: begin
                    oam_wdata <= cpu_din;
                    oam_we    <= 1'b1;
                  end
                  default: ;
                endcase
              end else begin
                cpu_dout <= rd_mux;
              end
              cpu_rdy <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end
        ST_VRAM_RD: begin
          if (vram_ack) begin
            vram_rd  <= 1'b0;
            cpu_dout <= vram_rd_val;
            read_buf <= vram_rdata;
            cpu_rdy  <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_VRAM_WR: begin
          if (vram_ack) begin
            vram_wr <= 1'b0;
            cpu_rdy <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          cpu_rdy <= 1'b0;
          // OAM sees the write at the old address; advance afterwards.
          if (oam_we) begin
            oam_we   <= 1'b0;
            oam_addr <= oam_addr + 8'd1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ppu_reg_if.sv
module tb_cpu_ppu_reg_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr_in;
  logic        addr_valid;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        cpu_rdy;
  logic        vblank_set, vblank_clr, spr0_hit, spr_ovf;
  logic [7:0]  ppu_ctrl, ppu_mask;
  logic [14:0] scroll_t;
  logic [2:0]  fine_x;
  logic [7:0]  oam_addr, oam_wdata, oam_rdata;
  logic        oam_we;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata, vram_rdata;
  logic        vram_rd, vram_wr, vram_ack;
  logic        nmi_out;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0]  vmem [0:16383];
  logic        auto_ack, man_ack;
  logic [7:0]  man_data;
  logic [13:0] last_wa;
  logic [7:0]  last_wd;

  always #5 clk = ~clk;

  cpu_ppu_reg_if dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .addr_valid(addr_valid),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_rdy(cpu_rdy), .vblank_set(vblank_set), .vblank_clr(vblank_clr),
    .spr0_hit(spr0_hit), .spr_ovf(spr_ovf), .ppu_ctrl(ppu_ctrl), .ppu_mask(ppu_mask),
    .scroll_t(scroll_t), .fine_x(fine_x), .oam_addr(oam_addr), .oam_wdata(oam_wdata),
    .oam_we(oam_we), .oam_rdata(oam_rdata), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_rd(vram_rd), .vram_wr(vram_wr),
    .vram_ack(vram_ack), .vram_rdata(vram_rdata), .nmi_out(nmi_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One CPU register access starting on a fresh cycle; returns read data
  // and cycles until cpu_rdy.
  task automatic acc(input logic wr, input logic [2:0] idx, input logic [7:0] d,
                     output logic [7:0] q, output int lat);
    @(negedge clk);
    addr_in = {13'h0400, idx};
    cpu_wr  = wr;
    cpu_rd  = ~wr;
    cpu_din = d;
    lat     = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (cpu_rdy) break;
    end
    chk("acc_rdy", {31'd0, cpu_rdy}, 32'd1);
    q      = cpu_dout;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [7:0] d);
    logic [7:0] q;
    int l;
    acc(1'b1, idx, d, q, l);
  endtask

  task automatic rd(input logic [2:0] idx, output logic [7:0] q);
    int l;
    acc(1'b0, idx, 8'h00, q, l);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q;
    int lat;
    logic seen;

    rst = 1'b1; addr_in = 16'h0; addr_valid = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    cpu_din = 8'h0; vblank_set = 1'b0; vblank_clr = 1'b0; spr0_hit = 1'b0;
    spr_ovf = 1'b0; oam_rdata = 8'h5C; vram_ack = 1'b0; vram_rdata = 8'h0;
    auto_ack = 1'b1; man_ack = 1'b0; man_data = 8'h0; last_wa = '0; last_wd = '0;
    for (int i = 0; i < 16384; i++) vmem[i] = 8'h00;
    vmem[14'h2000] = 8'hAA;
    vmem[14'h2001] = 8'hBB;
    vmem[14'h2002] = 8'hCC;
    vmem[14'h3F00] = 8'h0F;

    // VRAM responder: ack two cycles after a request appears
    fork
      begin
        int dly = 0;
        forever begin
          @(negedge clk);
          if (auto_ack) begin
            vram_ack = 1'b0;
            if (vram_rd || vram_wr) begin
              if (dly == 2) begin
                vram_ack   = 1'b1;
                vram_rdata = vmem[vram_addr];
                if (vram_wr) begin
                  vmem[vram_addr] = vram_wdata;
                  last_wa = vram_addr;
                  last_wd = vram_wdata;
                end
                dly = 0;
              end else dly++;
            end else dly = 0;
          end else begin
            vram_ack   = man_ack;
            vram_rdata = man_data;
          end
        end
      end
    join_none

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_rdy",   {31'd0, cpu_rdy}, 32'd0);
    chk("rst_dout",  {24'd0, cpu_dout}, 32'd0);
    chk("rst_ctrl",  {24'd0, ppu_ctrl}, 32'd0);
    chk("rst_mask",  {24'd0, ppu_mask}, 32'd0);
    chk("rst_t",     {17'd0, scroll_t}, 32'd0);
    chk("rst_x",     {29'd0, fine_x}, 32'd0);
    chk("rst_oam",   {15'd0, oam_we, oam_addr, oam_wdata}, 32'd0);
    chk("rst_vram",  {16'd0, vram_rd, vram_wr, vram_addr}, 32'd0);
    chk("rst_nmi",   {31'd0, nmi_out}, 32'd0);
    rst = 1'b0;

    // $2002 read after reset, latency 1
    acc(1'b0, 3'd2, 8'h00, q, lat);
    chk("stat_rst", {24'd0, q}, 32'h00);
    chk("stat_lat", lat, 1);

    // APU/IO range and memory-space accesses are ignored
    @(negedge clk);
    addr_in = 16'h4014; cpu_wr = 1'b1; cpu_din = 8'hFF; seen = 1'b0;
    repeat (4) begin @(negedge clk); seen |= cpu_rdy; end
    addr_in = 16'h2000; addr_valid = 1'b1;
    repeat (4) begin @(negedge clk); seen |= cpu_rdy; end
    cpu_wr = 1'b0; addr_valid = 1'b0;
    chk("ignore_rdy", {31'd0, seen}, 32'd0);
    chk("ignore_ctrl", {24'd0, ppu_ctrl}, 32'd0);

    wr(3'd1, 8'h1E);
    chk("mask", {24'd0, ppu_mask}, 32'h1E);

    // $2006 address load and $2007 writes with both increments
    wr(3'd6, 8'h21);
    chk("t_hi", {17'd0, scroll_t}, 32'h2100);
    wr(3'd6, 8'h08);
    chk("t_full", {17'd0, scroll_t}, 32'h2108);
    wr(3'd7, 8'h5A);
    chk("vwr_addr", {18'd0, last_wa}, 32'h2108);
    chk("vwr_data", {24'd0, last_wd}, 32'h5A);
    wr(3'd7, 8'h11);
    chk("vwr_inc1", {18'd0, last_wa}, 32'h2109);
    wr(3'd0, 8'h04);
    chk("ctrl", {24'd0, ppu_ctrl}, 32'h04);
    wr(3'd6, 8'h21);
    wr(3'd6, 8'h08);
    wr(3'd7, 8'h33);
    chk("vwr_a2", {18'd0, last_wa}, 32'h2108);
    wr(3'd7, 8'h44);
    chk("vwr_inc32", {18'd0, last_wa}, 32'h2128);

    // buffered reads then palette bypass
    wr(3'd0, 8'h00);
    wr(3'd6, 8'h20);
    wr(3'd6, 8'h00);
    rd(3'd7, q); chk("vrd_1", {24'd0, q}, 32'h00);
    rd(3'd7, q); chk("vrd_2", {24'd0, q}, 32'hAA);
    rd(3'd7, q); chk("vrd_3", {24'd0, q}, 32'hBB);
    wr(3'd6, 8'h3F);
    wr(3'd6, 8'h00);
    rd(3'd7, q); chk("vrd_pal", {24'd0, q}, 32'h0F);

    // scroll writes and w reset by $2002
    wr(3'd5, 8'h7D);
    chk("scr1_t", {17'd0, scroll_t}, 32'h3F0F);
    chk("scr1_x", {29'd0, fine_x}, 32'd5);
    rd(3'd2, q);
    wr(3'd5, 8'h5E);
    chk("scr2_t", {17'd0, scroll_t}, 32'h3F0B);
    chk("scr2_x", {29'd0, fine_x}, 32'd6);
    wr(3'd5, 8'hA3);
    chk("scr3_t", {17'd0, scroll_t}, 32'h3E8B);
    chk("scr3_x", {29'd0, fine_x}, 32'd6);
    wr(3'd0, 8'h00);
    chk("ctrl_t", {17'd0, scroll_t}, 32'h328B);

    // OAM port: write pulse, increment with wrap, read without increment
    wr(3'd3, 8'hFE);
    wr(3'd4, 8'h12);
    chk("oam_we", {15'd0, oam_we, oam_addr, oam_wdata}, {15'd0, 1'b1, 8'hFE, 8'h12});
    @(negedge clk);
    chk("oam_inc", {23'd0, oam_we, oam_addr}, {23'd0, 1'b0, 8'hFF});
    wr(3'd4, 8'h34);
    @(negedge clk);
    chk("oam_wrap", {24'd0, oam_addr}, 32'h00);
    rd(3'd4, q);
    chk("oam_rd", {24'd0, q}, 32'h5C);
    @(negedge clk);
    chk("oam_rd_noinc", {24'd0, oam_addr}, 32'h00);
    rd(3'd1, q);
    chk("wo_read", {24'd0, q}, 32'h00);

    // vblank / NMI
    wr(3'd0, 8'h80);
    @(negedge clk); vblank_set = 1'b1;
    @(negedge clk); vblank_set = 1'b0;
    chk("nmi_set", {31'd0, nmi_out}, 32'd1);
    spr0_hit = 1'b1;
    rd(3'd2, q);
    chk("stat_vbl", {24'd0, q}, 32'hC0);
    chk("nmi_clr", {31'd0, nmi_out}, 32'd0);
    @(negedge clk); vblank_set = 1'b1;
    @(negedge clk); vblank_set = 1'b0;
    chk("nmi_set2", {31'd0, nmi_out}, 32'd1);
    wr(3'd0, 8'h00);
    chk("nmi_off", {31'd0, nmi_out}, 32'd0);
    wr(3'd0, 8'h80);
    chk("nmi_reraise", {31'd0, nmi_out}, 32'd1);
    spr0_hit = 1'b0; spr_ovf = 1'b1;
    rd(3'd2, q);
    chk("stat_ovf", {24'd0, q}, 32'hA0);

    // set coinciding with the status read is suppressed
    @(negedge clk);
    addr_in = 16'h2002; cpu_rd = 1'b1; vblank_set = 1'b1;
    @(negedge clk);
    vblank_set = 1'b0;
    chk("supp_rdy", {31'd0, cpu_rdy}, 32'd1);
    chk("supp_dout", {24'd0, cpu_dout}, 32'h20);
    cpu_rd = 1'b0;
    repeat (2) @(negedge clk);
    chk("supp_nmi", {31'd0, nmi_out}, 32'd0);
    rd(3'd2, q);
    chk("supp_stat", {24'd0, q}, 32'h20);

    // clear wins over set
    @(negedge clk); vblank_set = 1'b1; vblank_clr = 1'b1;
    @(negedge clk); vblank_set = 1'b0; vblank_clr = 1'b0;
    chk("clr_wins", {31'd0, nmi_out}, 32'd0);

    // reset during a pending VRAM read; late ack ignored
    auto_ack = 1'b0;
    @(negedge clk);
    addr_in = 16'h2007; cpu_rd = 1'b1;
    repeat (2) @(negedge clk);
    chk("pend_rd", {31'd0, vram_rd}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_drop", {30'd0, vram_rd, cpu_rdy}, 32'd0);
    rst = 1'b0; cpu_rd = 1'b0;
    man_data = 8'hEE; man_ack = 1'b1;
    repeat (2) @(negedge clk);
    man_ack = 1'b0;
    seen = cpu_rdy;
    repeat (2) @(negedge clk);
    seen |= cpu_rdy;
    chk("late_ack_rdy", {31'd0, seen}, 32'd0);
    auto_ack = 1'b1;
    acc(1'b0, 3'd2, 8'h00, q, lat);
    chk("post_rst_lat", lat, 1);
    wr(3'd6, 8'h20);
    wr(3'd6, 8'h00);
    rd(3'd7, q);
    chk("late_ack_buf", {24'd0, q}, 32'h00);
    rd(3'd7, q);
    chk("post_rst_rd", {24'd0, q}, 32'hAA);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
